// File: rtl/reg_write_arbiter.sv
// Register-file write-port owner: clears every register after reset, then
// shares the port round-robin between an ALU requester (A) and a load requester (B).
module reg_write_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              EscReg,
  output logic [ADDR_W-1:0] RegEsc,
  output logic [DATA_W-1:0] DadoEscr,
  output logic              init_done,
  output logic              last_grant,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic                prio_q, prio_d;  // 0 = A has priority, 1 = B
  logic                esc_q, esc_d;
  logic [ADDR_W-1:0]   reg_q, reg_d;
  logic [DATA_W-1:0]   dado_q, dado_d;
  logic                init_done_q, init_done_d;
  logic                last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    conflict_q, conflict_d;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (state_q == StRun) begin
      if (a_valid && (!b_valid || !prio_q)) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    prio_d       = prio_q;
    esc_d        = 1'b0;
    reg_d        = reg_q;
    dado_d       = dado_q;
    init_done_d  = init_done_q;
    last_grant_d = last_grant_q;
    conflict_d   = conflict_q;
    unique case (state_q)
      StInit: begin
        esc_d      = 1'b1;
        reg_d      = init_cnt_q;
        dado_d     = '0;
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end
      end
      StRun: begin
        if (a_ready) begin
          esc_d        = 1'b1;
          reg_d        = a_addr;
          dado_d       = a_data;
          last_grant_d = 1'b0;
          prio_d       = 1'b1;
        end else if (b_ready) begin
          esc_d        = 1'b1;
          reg_d        = b_addr;
          dado_d       = b_data;
          last_grant_d = 1'b1;
          prio_d       = 1'b0;
        end
        // Saturate rather than wrap so a long contention run stays visible.
        if (a_valid && b_valid && (conflict_q != '1)) begin
          conflict_d = conflict_q + CNT_W'(1);
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StInit;
      init_cnt_q   <= '0;
      prio_q       <= 1'b0;
      esc_q        <= 1'b0;
      reg_q        <= '0;
      dado_q       <= '0;
      init_done_q  <= 1'b0;
      last_grant_q <= 1'b0;
      conflict_q   <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      prio_q       <= prio_d;
      esc_q        <= esc_d;
      reg_q        <= reg_d;
      dado_q       <= dado_d;
      init_done_q  <= init_done_d;
      last_grant_q <= last_grant_d;
      conflict_q   <= conflict_d;
    end
  end

  assign EscReg       = esc_q;
  assign RegEsc       = reg_q;
  assign DadoEscr     = dado_q;
  assign init_done    = init_done_q;
  assign last_grant   = last_grant_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter; a second instance with a 2-bit counter
// shares the stimulus to exercise conflict-counter saturation.
module tb_reg_write_arbiter;

  logic       clock, reset;
  logic       a_valid, b_valid;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, esc, init_done, last_grant;
  logic [2:0] reg_esc;
  logic [7:0] dado, conflict_cnt;
  logic       s_a_ready, s_b_ready, s_esc, s_init_done, s_last_grant;
  logic [2:0] s_reg_esc;
  logic [7:0] s_dado;
  logic [1:0] s_conflict;

  int n_vec = 0;
  int n_err = 0;

  reg_write_arbiter u_dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .EscReg(esc), .RegEsc(reg_esc), .DadoEscr(dado),
    .init_done(init_done), .last_grant(last_grant), .conflict_cnt(conflict_cnt)
  );

  reg_write_arbiter #(.CNT_W(2)) u_small (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(s_a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(s_b_ready), .b_addr(b_addr), .b_data(b_data),
    .EscReg(s_esc), .RegEsc(s_reg_esc), .DadoEscr(s_dado),
    .init_done(s_init_done), .last_grant(s_last_grant), .conflict_cnt(s_conflict)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " esc"}, {31'd0, esc}, 32'd0);
    check_eq({tag, " reg"}, {29'd0, reg_esc}, 32'd0);
    check_eq({tag, " dado"}, {24'd0, dado}, 32'd0);
    check_eq({tag, " init_done"}, {31'd0, init_done}, 32'd0);
    check_eq({tag, " last_grant"}, {31'd0, last_grant}, 32'd0);
    check_eq({tag, " conflict"}, {24'd0, conflict_cnt}, 32'd0);
    check_eq({tag, " a_ready"}, {31'd0, a_ready}, 32'd0);
    check_eq({tag, " b_ready"}, {31'd0, b_ready}, 32'd0);
  endtask

  // One full clear sequence; valids stay as the caller left them.
  task automatic run_init(input string tag);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq({tag, " esc"}, {31'd0, esc}, 32'd1);
      check_eq({tag, " reg"}, {29'd0, reg_esc}, i);
      check_eq({tag, " dado"}, {24'd0, dado}, 32'd0);
      check_eq({tag, " init_done"}, {31'd0, init_done}, (i == 7) ? 32'd1 : 32'd0);
      if (i < 7) begin
        check_eq({tag, " a_ready"}, {31'd0, a_ready}, 32'd0);
        check_eq({tag, " b_ready"}, {31'd0, b_ready}, 32'd0);
      end
      check_eq({tag, " conflict"}, {24'd0, conflict_cnt}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    #2;
    check_all_zero("reset");
    tick();
    reset = 1'b1;

    // Clear sequence with no requests, then idle.
    run_init("init1");
    tick();
    check_eq("idle esc", {31'd0, esc}, 32'd0);

    // Single A write.
    a_valid = 1'b1; a_addr = 3'b010; a_data = 8'hFF;
    #1;
    check_eq("single a_ready", {31'd0, a_ready}, 32'd1);
    check_eq("single b_ready", {31'd0, b_ready}, 32'd0);
    tick();
    a_valid = 1'b0;
    check_eq("single esc", {31'd0, esc}, 32'd1);
    check_eq("single reg", {29'd0, reg_esc}, 32'd2);
    check_eq("single dado", {24'd0, dado}, 32'hFF);
    check_eq("single grant", {31'd0, last_grant}, 32'd0);
    tick();
    check_eq("hold esc", {31'd0, esc}, 32'd0);
    check_eq("hold reg", {29'd0, reg_esc}, 32'd2);
    check_eq("hold dado", {24'd0, dado}, 32'hFF);

    // Reset again and abort the clear at address 4.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_eq("abort pre reg", {29'd0, reg_esc}, 32'd4);
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    tick();
    reset = 1'b1;

    // Both requesters valid through a full restarted clear.
    a_valid = 1'b1; a_addr = 3'b010; a_data = 8'hAA;
    b_valid = 1'b1; b_addr = 3'b011; b_data = 8'h55;
    run_init("init2");
    check_eq("init2 small conflict", {30'd0, s_conflict}, 32'd0);

    // Contention: grants alternate starting with A.
    for (int k = 0; k < 6; k++) begin
      check_eq("rr a_ready", {31'd0, a_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("rr b_ready", {31'd0, b_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      check_eq("rr esc", {31'd0, esc}, 32'd1);
      check_eq("rr reg", {29'd0, reg_esc}, (k % 2 == 0) ? 32'd2 : 32'd3);
      check_eq("rr dado", {24'd0, dado}, (k % 2 == 0) ? 32'hAA : 32'h55);
      check_eq("rr grant", {31'd0, last_grant}, (k % 2 == 0) ? 32'd0 : 32'd1);
      check_eq("rr conflict", {24'd0, conflict_cnt}, k + 1);
      check_eq("sat conflict", {30'd0, s_conflict}, (k < 3) ? k + 1 : 32'd3);
    end

    // A alone, back-to-back every cycle.
    b_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_addr = 3'(k + 5);
      a_data = 8'(8'h11 * (k + 1));
      #1;
      check_eq("b2b a_ready", {31'd0, a_ready}, 32'd1);
      tick();
      check_eq("b2b esc", {31'd0, esc}, 32'd1);
      check_eq("b2b reg", {29'd0, reg_esc}, k + 5);
      check_eq("b2b dado", {24'd0, dado}, 8'h11 * (k + 1));
      check_eq("b2b conflict", {24'd0, conflict_cnt}, 32'd6);
    end

    // B alone after A: B ready, same-address follow-up write.
    a_valid = 1'b0;
    b_valid = 1'b1; b_addr = 3'd7; b_data = 8'h3C;
    #1;
    check_eq("b only ready", {31'd0, b_ready}, 32'd1);
    tick();
    b_valid = 1'b0;
    check_eq("b only reg", {29'd0, reg_esc}, 32'd7);
    check_eq("b only dado", {24'd0, dado}, 32'h3C);
    check_eq("b only grant", {31'd0, last_grant}, 32'd1);

    // Reset mid-RUN drops everything.
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("run reset");
    tick();
    reset = 1'b1;
    run_init("init3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
